// File: rtl/pwm_tone_sequencer.sv
// rtl/pwm_tone_sequencer.sv - note-sequence player driving a PWM beeper
// Plays ROM entries (code, length) with start/stop/pause, loop/one-shot and end marker.
module pwm_tone_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int SEQ_LEN    = 112,
   parameter int CNT_W      = 20,
   parameter int LEN_W      = 8,
   parameter int TICK_CYC   = 6250000,
   parameter int DUTY_SHIFT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic              loop_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_note,
   input  logic [LEN_W-1:0]  rom_len,
   output logic [7:0]        note_code,
   input  logic [CNT_W-1:0]  period,
   output logic              beep,
   output logic              busy,
   output logic              done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_PLAY  = 2'd3;

   localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SEQ_LEN - 1);

   logic [1:0]        state;
   logic [LEN_W-1:0]  len_reg;
   logic [LEN_W-1:0]  unit_cnt;
   logic [TICK_W-1:0] tick_cnt;
   logic [CNT_W-1:0]  pwm_cnt;
   logic [CNT_W-1:0]  duty;
   logic              tick_wrap;
   logic              note_end;
   logic              pwm_wrap;
   logic              tone_on;

   assign duty      = period >> DUTY_SHIFT;
   assign tick_wrap = (tick_cnt == TICK_LAST);
   assign note_end  = tick_wrap && (unit_cnt == len_reg - LEN_W'(1));
   // A shrinking period can leave pwm_cnt beyond the new end; restart from 0 then.
   assign pwm_wrap  = (period == '0) || (pwm_cnt >= period - CNT_W'(1));
   assign tone_on   = (note_code != 8'd0) && (period != '0) && (pwm_cnt >= duty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         rom_addr  <= '0;
         note_code <= '0;
         len_reg   <= '0;
         unit_cnt  <= '0;
         tick_cnt  <= '0;
         pwm_cnt   <= '0;
         beep      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         beep <= 1'b0;
         busy <= (state != S_IDLE);
         if (stop) begin
            state    <= S_IDLE;
            rom_addr <= '0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state    <= S_FETCH;
                     rom_addr <= '0;
                  end
               end
               S_FETCH: state <= S_LOAD;
               S_LOAD: begin
                  note_code <= rom_note;
                  len_reg   <= rom_len;
                  tick_cnt  <= '0;
                  unit_cnt  <= '0;
                  pwm_cnt   <= '0;
                  if (rom_len == '0) begin
                     if (loop_en) begin
                        rom_addr <= '0;
                        state    <= S_FETCH;
                     end else begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                     end
                  end else begin
                     state <= S_PLAY;
                  end
               end
               S_PLAY: begin
                  if (!pause) begin
                     if (note_end) begin
                        if (rom_addr == ADDR_LAST) begin
                           if (loop_en) begin
                              rom_addr <= '0;
                              state    <= S_FETCH;
                           end else begin
                              state <= S_IDLE;
                              done  <= 1'b1;
                           end
                        end else begin
                           rom_addr <= rom_addr + ADDR_W'(1);
                           state    <= S_FETCH;
                        end
                     end else begin
                        if (tick_wrap) begin
                           tick_cnt <= '0;
                           unit_cnt <= unit_cnt + LEN_W'(1);
                        end else begin
                           tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                        pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + CNT_W'(1);
                        beep    <= tone_on;
                     end
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_tone_sequencer.sv
// tb/tb_pwm_tone_sequencer.sv - self-checking bench for pwm_tone_sequencer
// Cycle model tracks gap/play progress by elapsed-cycle arithmetic.
module tb_pwm_tone_sequencer;

   localparam int ADDR_W     = 8;
   localparam int SEQ_LEN    = 4;
   localparam int CNT_W      = 20;
   localparam int LEN_W      = 8;
   localparam int TICK_CYC   = 10;
   localparam int DUTY_SHIFT = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              stop = 1'b0;
   logic              pause = 1'b0;
   logic              loop_en = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [7:0]        rom_note;
   logic [LEN_W-1:0]  rom_len;
   logic [7:0]        note_code;
   logic [CNT_W-1:0]  period;
   logic              beep;
   logic              busy;
   logic              done;

   logic [7:0]        mem_note [SEQ_LEN];
   logic [LEN_W-1:0]  mem_len  [SEQ_LEN];
   logic              use_tab = 1'b0;
   logic [CNT_W-1:0]  period_drv = 20'd8;

   int checks = 0;
   int errors = 0;

   pwm_tone_sequencer #(
      .ADDR_W(ADDR_W), .SEQ_LEN(SEQ_LEN), .CNT_W(CNT_W),
      .LEN_W(LEN_W), .TICK_CYC(TICK_CYC), .DUTY_SHIFT(DUTY_SHIFT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
      .loop_en(loop_en), .rom_addr(rom_addr), .rom_note(rom_note),
      .rom_len(rom_len), .note_code(note_code), .period(period),
      .beep(beep), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      int a;
      a = int'(rom_addr);
      if (a < SEQ_LEN) begin
         rom_note <= mem_note[a];
         rom_len  <= mem_len[a];
      end else begin
         rom_note <= 8'd0;
         rom_len  <= '0;
      end
   end

   assign period = use_tab ? CNT_W'(note_code[3:0]) : period_drv;

   // Reference model: idle flag, remaining gap cycles, unpaused cycles played in note.
   bit   m_idle = 1'b1;
   int   m_gap = 0;
   int   m_addr = 0;
   int   m_len = 0;
   int   m_played = 0;
   logic [7:0] m_code = 8'd0;
   bit   e_beep = 1'b0, e_busy = 1'b0, e_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit tone(input int played);
      int p;
      p = use_tab ? int'(m_code[3:0]) : int'(period_drv);
      if (m_code == 8'd0 || p == 0) return 1'b0;
      return (played % p) >= (p >> DUTY_SHIFT);
   endfunction

   task automatic seq_end();
      if (loop_en) begin
         m_addr = 0;
         m_gap  = 2;
      end else begin
         m_idle = 1'b1;
         e_done = 1'b1;
      end
   endtask

   task automatic model_reset();
      m_idle = 1'b1; m_gap = 0; m_addr = 0; m_len = 0; m_played = 0; m_code = 8'd0;
      e_beep = 1'b0; e_busy = 1'b0; e_done = 1'b0;
   endtask

   task automatic model_step();
      e_done = 1'b0;
      e_beep = 1'b0;
      e_busy = !m_idle;
      if (stop) begin
         m_idle = 1'b1;
         m_addr = 0;
         e_busy = 1'b0;
      end else if (m_idle) begin
         if (start) begin
            m_idle = 1'b0;
            m_gap  = 2;
            m_addr = 0;
         end
      end else if (m_gap == 2) begin
         m_gap = 1;
      end else if (m_gap == 1) begin
         m_code = mem_note[m_addr];
         m_len  = int'(mem_len[m_addr]);
         if (m_len == 0) seq_end();
         else begin
            m_gap    = 0;
            m_played = 0;
         end
      end else if (!pause) begin
         if (m_played == m_len * TICK_CYC - 1) begin
            if (m_addr == SEQ_LEN - 1) seq_end();
            else begin
               m_addr++;
               m_gap = 2;
            end
         end else begin
            e_beep = tone(m_played);
            m_played++;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check("rom_addr", 32'(rom_addr), 32'(m_addr));
      check("beep", 32'(beep), 32'(e_beep));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("note_code", 32'(note_code), 32'(m_code));
   endtask

   task automatic load_rom(input logic [31:0] codes, input logic [31:0] lens);
      for (int i = 0; i < SEQ_LEN; i++) begin
         mem_note[i] = codes[8*i +: 8];
         mem_len[i]  = lens[8*i +: 8];
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   typedef struct {
      logic [31:0] codes;
      logic [31:0] lens;
      int          exp_done_at;
      int          exp_high;
      int          exp_max_addr;
   } vec_t;

   vec_t vecs [6];

   initial begin
      int done_at, high, maxa, ndone, busy_hi;

      vecs[0] = '{32'h04030201, 32'h01030102, 78, 46, 3};
      vecs[1] = '{32'h04030201, 32'h05050001, 14,  6, 1};
      vecs[2] = '{32'h04030201, 32'h01010100,  2,  0, 0};
      vecs[3] = '{32'h04030201, 32'h01010101, 48, 24, 3};
      vecs[4] = '{32'h07060005, 32'h01010201, 58, 18, 3};
      vecs[5] = '{32'h07060005, 32'h05000201, 36,  6, 2};
      load_rom(32'h04030201, 32'h01010101);

      #8;
      check("reset_rom_addr", 32'(rom_addr), 0);
      check("reset_beep", 32'(beep), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_done", 32'(done), 0);
      check("reset_note_code", 32'(note_code), 0);
      #4 rst_n = 1'b1;
      repeat (2) tick();

      for (int v = 0; v < 6; v++) begin
         load_rom(vecs[v].codes, vecs[v].lens);
         pulse_start();
         done_at = -1; high = 0; maxa = 0;
         for (int n = 1; n <= 300 && done_at < 0; n++) begin
            tick();
            high += int'(beep);
            if (int'(rom_addr) > maxa) maxa = int'(rom_addr);
            if (done) begin
               done_at = n;
               check("vec_busy_at_done", 32'(busy), 1);
            end
         end
         check("vec_done_at", done_at, vecs[v].exp_done_at);
         check("vec_beep_high", high, vecs[v].exp_high);
         check("vec_max_addr", maxa, vecs[v].exp_max_addr);
         tick();
         check("vec_busy_fall", 32'(busy), 0);
         repeat (2) tick();
      end

      // Loop mode, cleared during the second pass
      load_rom(32'h04030201, 32'h01010101);
      loop_en = 1'b1;
      pulse_start();
      done_at = -1;
      for (int n = 1; n <= 200 && done_at < 0; n++) begin
         tick();
         if (n == 48) begin
            check("loop_wrap_addr", 32'(rom_addr), 0);
            check("loop_no_done", 32'(done), 0);
         end
         if (n == 60) loop_en = 1'b0;
         if (done) done_at = n;
      end
      check("loop_done_at", done_at, 96);
      repeat (2) tick();

      // Pause 5 cycles into a one-unit note for 7 cycles
      load_rom(32'h04030201, 32'h05050001);
      pulse_start();
      done_at = -1;
      for (int n = 1; n <= 100 && done_at < 0; n++) begin
         if (n == 7) pause = 1'b1;
         if (n == 14) pause = 1'b0;
         tick();
         if (n >= 7 && n <= 13) check("pause_beep", 32'(beep), 0);
         if (done) done_at = n;
      end
      check("pause_done_at", done_at, 21);
      repeat (2) tick();

      // Stop mid-note
      load_rom(32'h04030201, 32'h03030303);
      pulse_start();
      for (int n = 1; n <= 5; n++) tick();
      check("stop_pre_beep", 32'(beep), 1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("stop_beep", 32'(beep), 0);
      check("stop_busy", 32'(busy), 0);
      check("stop_addr", 32'(rom_addr), 0);
      ndone = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         ndone += int'(done);
      end
      check("stop_no_done", ndone, 0);

      // start and stop together from idle
      start = 1'b1; stop = 1'b1;
      tick();
      start = 1'b0; stop = 1'b0;
      busy_hi = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         busy_hi += int'(busy);
      end
      check("start_stop_idle", busy_hi, 0);

      // start while busy is ignored
      load_rom(32'h04030201, 32'h01010101);
      pulse_start();
      done_at = -1;
      for (int n = 1; n <= 200 && done_at < 0; n++) begin
         start = (n == 20 || n == 35);
         tick();
         if (done) done_at = n;
      end
      start = 1'b0;
      check("start_busy_ignored", done_at, 48);
      repeat (2) tick();

      // Async reset mid-note
      load_rom(32'h04030201, 32'h03030303);
      pulse_start();
      for (int i = 0; i < 50 && !beep; i++) tick();
      check("rst_pre_beep", 32'(beep), 1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_beep", 32'(beep), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_addr", 32'(rom_addr), 0);
      #3 rst_n = 1'b1;
      busy_hi = 0;
      for (int n = 0; n < 20; n++) begin
         tick();
         busy_hi += int'(busy) + int'(beep);
      end
      check("rst_stays_idle", busy_hi, 0);

      // Randomised episodes against the model
      use_tab = 1'b1;
      for (int ep = 0; ep < 10; ep++) begin
         stop = 1'b1;
         tick();
         stop = 1'b0;
         for (int i = 0; i < SEQ_LEN; i++) begin
            mem_note[i] = 8'($urandom_range(0, 20));
            mem_len[i]  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 3));
         end
         for (int n = 0; n < 300; n++) begin
            start = ($urandom_range(0, 9) == 0);
            stop  = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            if ($urandom_range(0, 19) == 0) loop_en = ~loop_en;
            tick();
         end
         start = 1'b0; stop = 1'b0; pause = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_tone_sequencer.md
Name: pwm_tone_sequencer

Overview:
- Parametrised note-sequence player driving a PWM piezo/beeper output. Successor to the fixed single-song beeper.
- Steps through an external synchronous note ROM holding a note code and a length per entry. Exports the note code to an external combinational period lookup and generates a PWM tone of configurable duty.
- Adds start/stop/pause control, loop or one-shot mode, rests, an end-of-song marker, and busy/done status.
- Sits between the song ROMs, the note-to-period table and the beeper pin.

Parameters:
- ADDR_W, 8, ROM address width.
- SEQ_LEN, 112, number of ROM entries played (last address = SEQ_LEN-1); must be ≤ 2^ADDR_W.
- CNT_W, 20, width of the tone period and PWM counter.
- LEN_W, 8, width of the note length field (in ticks).
- TICK_CYC, 6250000, clk cycles per length tick (125 ms at 50 MHz).
- DUTY_SHIFT, 2, duty threshold = period >> DUTY_SHIFT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins playback at address 0 when idle.
- stop  in  1  synchronous abort, highest priority.
- pause  in  1  level; freezes playback while high.
- loop_en  in  1  1 = wrap to address 0 after the last entry.
- rom_addr  out  ADDR_W  note ROM address (registered).
- rom_note  in  8  note code; valid 1 cycle after rom_addr.
- rom_len  in  LEN_W  note length in ticks; valid 1 cycle after rom_addr.
- note_code  out  8  latched code of the current note, to the period lookup.
- period  in  CNT_W  tone period in clk cycles for note_code (combinational lookup).
- beep  out  1  PWM output (registered).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at the natural end of a one-shot sequence.

Behaviour:
- Reset: asynchronous, active-low, on rst_n. All of rom_addr, note_code, beep, busy, done = 0; state = IDLE; all counters = 0.
- FSM states are IDLE, FETCH, LOAD, PLAY.
- IDLE: start=1 → FETCH with rom_addr=0. start is ignored in any other state.
- FETCH (1 cycle): rom_addr is stable; ROM data is valid next cycle. → LOAD.
- LOAD (1 cycle): samples rom_note into note_code and rom_len into len_reg.
  - If rom_len==0: entry is the end marker; take the end-of-sequence action.
  - Otherwise clear tick_cnt, unit_cnt and pwm_cnt and go to PLAY.
- PLAY:
  - tick_cnt counts 0..TICK_CYC-1; at wrap, unit_cnt increments.
  - The note ends on the cycle where tick_cnt==TICK_CYC-1 and unit_cnt==len_reg-1. Note duration in PLAY is exactly len_reg*TICK_CYC cycles; no multiplier is used.
  - At note end, if rom_addr==SEQ_LEN-1, take the end-of-sequence action; otherwise rom_addr+1 → FETCH.
- End-of-sequence action:
  - loop_en=1 (sampled at that cycle): rom_addr=0 → FETCH.
  - loop_en=0: → IDLE and pulse done for 1 cycle.
- Inter-note gap: FETCH+LOAD = 2 cycles with beep=0.
- PWM, PLAY only:
  - pwm_cnt counts 0..period-1 and restarts at 0; duty = period >> DUTY_SHIFT.
  - Next-cycle beep = (pwm_cnt >= duty).
  - With DUTY_SHIFT=2: low 1/4 of the period, high 3/4.
  - period is sampled every cycle; a period decrease below pwm_cnt forces pwm_cnt to 0 on the next cycle.
- Rest: note_code==0 or period==0 → beep held 0; note timing continues normally.
- beep=0 in IDLE, FETCH and LOAD.
- pause=1 during PLAY:
  - tick_cnt, unit_cnt and pwm_cnt hold; beep forced 0 next cycle.
  - On release, counting resumes from the held values.
  - pause is ignored in other states (FETCH/LOAD complete, then PLAY starts paused).
- stop=1 in any state:
  - Next cycle: IDLE, beep=0, busy=0, rom_addr=0; done is not pulsed.
  - stop and start in the same cycle: stop wins.
- busy is registered from the state: 1 the cycle after start is accepted, 0 the cycle after reaching IDLE.
- Reset asserted mid-note: immediate return to reset values; no residual beep.
- Width rules:
  - tick_cnt is sized ceil(log2(TICK_CYC)).
  - unit_cnt is LEN_W bits.
  - period >> DUTY_SHIFT is truncating.
  - period==1 gives duty 0 and beep constantly 1.

Test Plan:
- Bench parameters: TICK_CYC=10, SEQ_LEN=4, DUTY_SHIFT=2.
- One-shot: ROM lens {2,1,3,1}, codes nonzero, period=8, loop_en=0, start pulse.
  - PLAY lengths 20/10/30/10 cycles, each preceded by a 2-cycle gap.
  - beep pattern per period is 2 low / 6 high.
  - done pulses once and busy falls 1 cycle later.
- Loop: same ROM with loop_en=1. After address 3, rom_addr returns to 0 with no done pulse. Clear loop_en mid-second pass → done after that pass.
- Rest and end marker:
  - Entry 1 with code 0, len 2 → beep 0 for 20 cycles.
  - Entry 2 with len 0 → IDLE plus done directly after entry 1; entry 3 is never fetched.
- Pause: assert pause 5 cycles into a len-1 note and hold for 7 cycles → beep 0 during the pause; note PLAY total = 17 cycles; pwm phase resumes where it stopped.
- Stop/start priority:
  - stop mid-PLAY → next cycle beep=0, busy=0, rom_addr=0, no done.
  - start+stop in the same cycle from IDLE → remains IDLE.
  - start while busy → ignored.
- Async reset: drop rst_n mid-note while beep=1 → beep, busy and rom_addr are 0 immediately. After release, nothing plays until start.
